// File: rtl/uart_module.sv
// uart_module: self-exercising 8N1 UART (one transmitter, one receiver).
//   The transmitter sends 0x00, 0x01, 0x02, ... forever, with an idle-high
//   gap of IDLE_GAP clocks before each frame. The receiver deserialises Rx
//   and keeps the last correctly framed byte.
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous reset, active low
//   Rx       serial input, idle high, asynchronous to clk
//   Tx       serial output, idle high, registered
//   tx_data  byte being (or about to be) transmitted
//   data     last received byte whose stop bit was 1
module uart_module #(
  parameter int CLKS_PER_BIT = 434,
  parameter int IDLE_GAP     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rx,
  output logic       Tx,
  output logic [7:0] tx_data,
  output logic [7:0] data
);

  localparam int CMAX = (CLKS_PER_BIT > IDLE_GAP) ? CLKS_PER_BIT : IDLE_GAP;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(IDLE_GAP - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {TX_GAP, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------------------------------------------------------- TX
  tx_state_t     tx_st, tx_st_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_idx, tx_idx_n;
  logic          tx_n;
  logic [7:0]    tx_data_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_st   <= TX_GAP;
      tx_cnt  <= '0;
      tx_idx  <= '0;
      Tx      <= 1'b1;
      tx_data <= 8'h00;
    end else begin
      tx_st   <= tx_st_n;
      tx_cnt  <= tx_cnt_n;
      tx_idx  <= tx_idx_n;
      Tx      <= tx_n;
      tx_data <= tx_data_n;
    end
  end

  // Tx is computed from the *next* state so the line register changes in
  // the same cycle as the state, keeping every bit exactly one period long.
  always_comb begin
    tx_st_n   = tx_st;
    tx_cnt_n  = tx_cnt + CW'(1);
    tx_idx_n  = tx_idx;
    tx_n      = 1'b1;
    tx_data_n = tx_data;
    case (tx_st)
      TX_GAP: begin
        if (tx_cnt == GAP_LAST) begin
          tx_st_n  = TX_START;
          tx_cnt_n = '0;
          tx_n     = 1'b0;
        end
      end
      TX_START: begin
        tx_n = 1'b0;
        if (tx_cnt == BIT_LAST) begin
          tx_st_n  = TX_DATA;
          tx_cnt_n = '0;
          tx_idx_n = '0;
          tx_n     = tx_data[0];
        end
      end
      TX_DATA: begin
        tx_n = tx_data[tx_idx];
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_idx == 3'd7) begin
            tx_st_n = TX_STOP;
            tx_n    = 1'b1;
          end else begin
            tx_idx_n = tx_idx + 3'd1;
            tx_n     = tx_data[tx_idx + 3'd1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_st_n   = TX_GAP;
          tx_cnt_n  = '0;
          tx_data_n = tx_data + 8'd1;
        end
      end
      default: begin
        tx_st_n  = TX_GAP;
        tx_cnt_n = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------- RX
  // Two-flop synchroniser; rx_sync[1] is the only Rx view the FSM uses.
  logic [1:0] rx_sync;
  logic       rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], Rx};
  end

  assign rx_s = rx_sync[1];

  rx_state_t     rx_st, rx_st_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_idx, rx_idx_n;
  logic [7:0]    rx_sh, rx_sh_n;
  logic [7:0]    data_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_st  <= RX_IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh  <= '0;
      data   <= 8'h00;
    end else begin
      rx_st  <= rx_st_n;
      rx_cnt <= rx_cnt_n;
      rx_idx <= rx_idx_n;
      rx_sh  <= rx_sh_n;
      data   <= data_n;
    end
  end

  // START waits half a bit so every later sample lands mid-bit. After the
  // stop sample the FSM is back in IDLE, so a start edge arriving in the
  // second half of the stop bit is picked up on the next clock.
  always_comb begin
    rx_st_n  = rx_st;
    rx_cnt_n = rx_cnt + CW'(1);
    rx_idx_n = rx_idx;
    rx_sh_n  = rx_sh;
    data_n   = data;
    case (rx_st)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (!rx_s) rx_st_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n = '0;
          rx_idx_n = '0;
          rx_st_n  = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n = '0;
          rx_sh_n  = {rx_s, rx_sh[7:1]};
          if (rx_idx == 3'd7) rx_st_n  = RX_STOP;
          else                rx_idx_n = rx_idx + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n = '0;
          rx_st_n  = RX_IDLE;
          if (rx_s) data_n = rx_sh;
        end
      end
      default: begin
        rx_st_n  = RX_IDLE;
        rx_cnt_n = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_module.sv
// Bench for uart_module with CLKS_PER_BIT=8, IDLE_GAP=16.
// The Tx line is compared clock by clock against a frame-level model; the
// receiver is checked through a scoreboard: expected bytes are queued when
// stimulus is issued and a monitor pops one whenever data changes.
module tb_uart_module;

  localparam int CPB = 8;
  localparam int GAP = 16;
  localparam int PER = 10 * CPB + GAP;
  localparam int NF  = 260;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       loop = 1'b1;
  logic       ext_rx = 1'b1;
  logic       rx_line;
  logic       tx_w;
  logic [7:0] tx_data_w;
  logic [7:0] data_w;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic       mon_en = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         nrx = 0;
  logic [7:0] model_data;

  assign rx_line = loop ? tx_w : ext_rx;

  uart_module #(.CLKS_PER_BIT(CPB), .IDLE_GAP(GAP)) dut (
    .clk(clk), .rst(rst), .Rx(rx_line), .Tx(tx_w),
    .tx_data(tx_data_w), .data(data_w)
  );

  always #5 clk = ~clk;

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // Expected Tx level k clocks after reset release, from frame rules alone.
  function automatic logic exp_tx(input int k, input logic [7:0] first);
    int m, f, j;
    logic [7:0] b;
    if (k < GAP) return 1'b1;
    m = (k - GAP) % PER;
    f = (k - GAP) / PER;
    b = first + 8'(f);
    j = m / CPB;
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    return 1'b1;
  endfunction

  // Call right after the negedge on which rst was released.
  task automatic watch_frames(input int nf, input logic [7:0] first, input string tag);
    int errs, ff, k;
    logic [7:0] want_td;
    ff = -1;
    for (int f = 0; f < nf; f++) begin
      errs = 0;
      for (int i = 1; i <= PER; i++) begin
        k = f * PER + i;
        @(negedge clk);
        if (ff < 0 && tx_w === 1'b0) ff = k;
        want_td = first + 8'(k / PER);
        if (tx_w !== exp_tx(k, first) || tx_data_w !== want_td) begin
          if (errs == 0)
            $display("  note %s frame %0d clk %0d: Tx=%b tx_data=%h, model Tx=%b tx_data=%h",
                     tag, f, k, tx_w, tx_data_w, exp_tx(k, first), want_td);
          errs++;
        end
      end
      chk($sformatf("%s_frame%0d_wave", tag, f), errs, 0);
    end
    chk($sformatf("%s_first_fall", tag), ff, GAP);
  endtask

  task automatic drain(input int limit, input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("%s_drain", tag), exp_q.size(), 0);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      ext_rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    ext_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic glitch();
    ext_rx = 1'b0;
    repeat (2) @(negedge clk);
    ext_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Scoreboard monitor: every visible change of data consumes one entry.
  always @(negedge clk) begin
    logic [7:0] e;
    if (mon_en && data_w !== prev_data) begin
      nrx++;
      if (exp_q.size() == 0) begin
        chk($sformatf("rx_unexpected_%0d", nrx), data_w, prev_data);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("rx_byte_%0d", nrx), data_w, e);
        if (loop) chk($sformatf("rx_txdata_%0d", nrx), tx_data_w, e);
      end
    end
    prev_data = data_w;
  end

  initial begin
    logic [7:0] b;
    logic       ok;

    // ---- reset, frame shape, loopback through the 0xFF->0x00 wrap
    repeat (5) @(negedge clk);
    chk("rst_tx", tx_w, 1'b1);
    chk("rst_tx_data", tx_data_w, 8'h00);
    chk("rst_data", data_w, 8'h00);
    // Frame 0 carries 0x00, indistinguishable from the reset value of data.
    for (int f = 1; f < NF; f++) exp_q.push_back(8'(f));
    rst = 1'b1;
    mon_en = 1'b1;
    watch_frames(3, 8'h00, "a");
    drain(NF * PER + 200, "a");
    mon_en = 1'b0;

    // ---- reset in the DATA state of frame 5
    rst = 1'b0;
    repeat (3) @(negedge clk);
    exp_q.delete();
    for (int f = 1; f < 5; f++) exp_q.push_back(8'(f));
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (GAP + 5 * PER + 2 * CPB + 4) @(negedge clk);
    chk("b_pre_tx_data", tx_data_w, 8'h05);
    chk("b_pre_tx", tx_w, exp_tx(GAP + 5 * PER + 2 * CPB + 4, 8'h00));
    chk("b_pre_queue", exp_q.size(), 0);
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("b_rst_tx", tx_w, 1'b1);
    chk("b_rst_tx_data", tx_data_w, 8'h00);
    chk("b_rst_data", data_w, 8'h00);
    loop = 1'b0;
    ext_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    watch_frames(1, 8'h00, "b");

    // ---- external Rx: framing error, glitch, good frame, random traffic
    model_data = 8'h00;
    chk("c_start_data", data_w, model_data);
    mon_en = 1'b1;
    send_frame(8'hA5, 1'b0);
    chk("c_bad_stop_data", data_w, model_data);
    glitch();
    chk("c_glitch_data", data_w, model_data);
    exp_q.push_back(8'h3C);
    model_data = 8'h3C;
    send_frame(8'h3C, 1'b1);
    chk("c_good_3c", data_w, 8'h3C);
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      if (ok) begin
        if (b != model_data) exp_q.push_back(b);
        model_data = b;
      end
      send_frame(b, ok);
      if ($urandom_range(0, 2) == 0) glitch();
    end
    drain(4 * CPB, "c");
    chk("c_final_data", data_w, model_data);

    // ---- Rx stuck low: every frame fails its stop check
    ext_rx = 1'b0;
    repeat (40 * CPB) @(negedge clk);
    chk("c_low_data", data_w, model_data);
    mon_en = 1'b0;
    ext_rx = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
